// File: rtl/ram32k_arbiter_if.sv
// Requester and RAM-pin bundle for the 32K x 16 data RAM arbiter.
// slave = arbiter side, master = requesters plus the RAM read port.
interface ram32k_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              ram_load;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_in;
  logic [DATA_W-1:0] ram_out;
  logic              busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  ram_out,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_load, ram_address, ram_in, busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output ram_out,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_load, ram_address, ram_in, busy
  );
endinterface

// File: rtl/ram32k_arbiter.sv
// Two-requester arbiter/sequencer for the 32K x 16 data RAM.
// Define RAM_ARB_RR_EN for round-robin ties; default is fixed A-over-B priority.
module ram32k_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  ram32k_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              load_q, load_d;
  logic              win_b_q, win_b_d;
  logic              a_gnt_q, a_gnt_d;
  logic              b_gnt_q, b_gnt_d;
  logic              a_rv_q, a_rv_d;
  logic              b_rv_q, b_rv_d;
  logic [DATA_W-1:0] a_rd_q, a_rd_d;
  logic [DATA_W-1:0] b_rd_q, b_rd_d;
  logic              busy_q, busy_d;
  logic              pick_b;

`ifdef RAM_ARB_RR_EN
  logic last_b_q, last_b_d;

  // Tie goes to whichever port was not granted last.
  assign pick_b = bus.b_req & (~bus.a_req | ~last_b_q);
`else
  assign pick_b = bus.b_req & ~bus.a_req;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load_d  = 1'b0;
    win_b_d = win_b_q;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
    a_rv_d  = 1'b0;
    b_rv_d  = 1'b0;
    a_rd_d  = a_rd_q;
    b_rd_d  = b_rd_q;
`ifdef RAM_ARB_RR_EN
    last_b_d = last_b_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.a_req | bus.b_req) begin
          win_b_d = pick_b;
          addr_d  = pick_b ? bus.b_addr : bus.a_addr;
          wdata_d = pick_b ? bus.b_wdata : bus.a_wdata;
          load_d  = pick_b ? bus.b_we : bus.a_we;
          a_gnt_d = ~pick_b;
          b_gnt_d = pick_b;
`ifdef RAM_ARB_RR_EN
          last_b_d = pick_b;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // load_q doubles as the write flag of the access in flight.
        state_d = load_q ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        if (win_b_q) begin
          b_rd_d = bus.ram_out;
          b_rv_d = 1'b1;
        end else begin
          a_rd_d = bus.ram_out;
          a_rv_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= 1'b0;
      win_b_q <= 1'b0;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
      a_rd_q  <= '0;
      b_rd_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      win_b_q <= win_b_d;
      a_gnt_q <= a_gnt_d;
      b_gnt_q <= b_gnt_d;
      a_rv_q  <= a_rv_d;
      b_rv_q  <= b_rv_d;
      a_rd_q  <= a_rd_d;
      b_rd_q  <= b_rd_d;
      busy_q  <= busy_d;
    end
  end

`ifdef RAM_ARB_RR_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`endif

  assign bus.a_gnt       = a_gnt_q;
  assign bus.b_gnt       = b_gnt_q;
  assign bus.a_rvalid    = a_rv_q;
  assign bus.b_rvalid    = b_rv_q;
  assign bus.a_rdata     = a_rd_q;
  assign bus.b_rdata     = b_rd_q;
  assign bus.ram_load    = load_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_in      = wdata_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ram32k_arbiter.sv
// Self-checking bench for ram32k_arbiter with a behavioural 32K x 16 RAM.
// Read results are scoreboarded per port; tasks check timing inline.
module tb_ram32k_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram32k_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram32k_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  logic [DW-1:0] mem [0:32767] = '{default: '0};

  always @(posedge clk) begin
    if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
    else bus.ram_out <= mem[bus.ram_address];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int a_rv_cnt = 0;
  int b_rv_cnt = 0;
  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];
  logic [DW-1:0] shadow [int];
  logic [DW-1:0] mon_a, mon_b;

  function automatic logic [DW-1:0] sh(input logic [AW-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : '0;
  endfunction

  always @(negedge clk) begin
    if (bus.a_rvalid === 1'b1) begin
      a_rv_cnt++;
      n_cmp++;
      if (exp_a.size() == 0) begin
        n_bad++;
        $display("FAIL a_sb unexpected a_rvalid, a_rdata=%h", bus.a_rdata);
      end else begin
        mon_a = exp_a.pop_front();
        if (bus.a_rdata !== mon_a) begin
          n_bad++;
          $display("FAIL a_sb a_rdata=%h required %h", bus.a_rdata, mon_a);
        end
      end
    end
    if (bus.b_rvalid === 1'b1) begin
      b_rv_cnt++;
      n_cmp++;
      if (exp_b.size() == 0) begin
        n_bad++;
        $display("FAIL b_sb unexpected b_rvalid, b_rdata=%h", bus.b_rdata);
      end else begin
        mon_b = exp_b.pop_front();
        if (bus.b_rdata !== mon_b) begin
          n_bad++;
          $display("FAIL b_sb b_rdata=%h required %h", bus.b_rdata, mon_b);
        end
      end
    end
  end

  task automatic issue(input bit pb, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, output int lat);
    logic got;
    if (pb) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      got = pb ? bus.b_gnt : bus.a_gnt;
    end while (got !== 1'b1 && lat < 16);
    if (pb) bus.b_req = 1'b0;
    else bus.a_req = 1'b0;
    n_cmp++;
    if (got !== 1'b1) begin
      n_bad++;
      $display("FAIL gnt_timeout port=%0d no grant after %0d cycles, required grant", pb, lat);
    end else if (we) begin
      shadow[int'(addr)] = wd;
    end else if (pb) begin
      exp_b.push_back(sh(addr));
    end else begin
      exp_a.push_back(sh(addr));
    end
  endtask

  task automatic wait_done;
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((bus.busy !== 1'b0 || exp_a.size() != 0 || exp_b.size() != 0) && n < 20);
    n_cmp++;
    if (bus.busy !== 1'b0 || exp_a.size() != 0 || exp_b.size() != 0) begin
      n_bad++;
      $display("FAIL drain busy=%b pending a=%0d b=%0d, required idle with none pending",
               bus.busy, exp_a.size(), exp_b.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.ram_load, bus.busy,
         bus.ram_address, bus.ram_in, bus.a_rdata, bus.b_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs load=%b busy=%b addr=%h in=%h ard=%h brd=%h, required all 0",
               bus.ram_load, bus.busy, bus.ram_address, bus.ram_in, bus.a_rdata, bus.b_rdata);
    end
    exp_a.delete();
    exp_b.delete();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle busy=%b agnt=%b bgnt=%b, required 0 0 0",
               bus.busy, bus.a_gnt, bus.b_gnt);
    end
  endtask

  task automatic test_write_read;
    int lat;
    issue(1'b0, 1'b1, 15'h0005, 16'hBEEF, lat);
    n_cmp++;
    if (lat != 1 || bus.ram_load !== 1'b1 || bus.ram_address !== 15'h0005 ||
        bus.ram_in !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL wr_grant lat=%0d load=%b addr=%h in=%h, required 1 1 0005 beef",
               lat, bus.ram_load, bus.ram_address, bus.ram_in);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.ram_load !== 1'b0 || bus.a_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_load_pulse load=%b gnt=%b, required 0 0", bus.ram_load, bus.a_gnt);
    end
    issue(1'b0, 1'b0, 15'h0005, 16'h0000, lat);
    n_cmp++;
    if (lat != 1 || bus.ram_load !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_grant lat=%0d load=%b, required 1 0", lat, bus.ram_load);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.a_rvalid !== 1'b0 || bus.ram_load !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_capture rvalid=%b load=%b busy=%b, required 0 0 1",
               bus.a_rvalid, bus.ram_load, bus.busy);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL rd_latency rvalid=%b rdata=%h, required 1 beef", bus.a_rvalid, bus.a_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL rd_pulse rvalid=%b rdata=%h, required 0 beef", bus.a_rvalid, bus.a_rdata);
    end
    wait_done();
  endtask

`ifndef RAM_ARB_RR_EN
  task automatic test_fixed_prio;
    int na = 0;
    int nb = 0;
    int c = 0;
    bit got = 1'b0;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 15'h0100;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 15'h0200;
    while (na < 8 && c < 60) begin
      @(negedge clk);
      c++;
      if (bus.a_gnt === 1'b1) begin
        na++;
        exp_a.push_back(sh(15'h0100));
        if (na == 8) bus.a_req = 1'b0;
      end
      if (bus.b_gnt === 1'b1) begin
        nb++;
        exp_b.push_back(sh(15'h0200));
      end
    end
    n_cmp++;
    if (na != 8 || nb != 0) begin
      n_bad++;
      $display("FAIL prio_starve a_grants=%0d b_grants=%0d, required 8 0", na, nb);
    end
    c = 0;
    while (!got && c < 10) begin
      @(negedge clk);
      c++;
      if (bus.b_gnt === 1'b1) got = 1'b1;
    end
    bus.b_req = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL prio_b_after no B grant in %0d cycles, required B grant", c);
    end else begin
      exp_b.push_back(sh(15'h0200));
    end
    wait_done();
  endtask
`else
  task automatic test_round_robin;
    int c = 0;
    int ng = 0;
    int prev = 0;
    bit gb;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 15'h0100;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 15'h0200;
    while (ng < 8 && c < 60) begin
      @(negedge clk);
      c++;
      if (bus.a_gnt === 1'b1 || bus.b_gnt === 1'b1) begin
        gb = bus.b_gnt;
        if (gb) exp_b.push_back(sh(15'h0200));
        else exp_a.push_back(sh(15'h0100));
        n_cmp++;
        if (gb !== ng[0] || (bus.a_gnt & bus.b_gnt) || bus.busy !== 1'b1 ||
            (ng > 0 && c - prev != 3)) begin
          n_bad++;
          $display("FAIL rr_order grant%0d b=%b both=%b busy=%b gap=%0d, required b=%b busy=1 gap=3",
                   ng, gb, bus.a_gnt & bus.b_gnt, bus.busy, c - prev, ng[0]);
        end
        prev = c;
        ng++;
        if (ng == 8) begin
          bus.a_req = 1'b0;
          bus.b_req = 1'b0;
        end
      end
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    n_cmp++;
    if (ng != 8) begin
      n_bad++;
      $display("FAIL rr_count grants=%0d, required 8", ng);
    end
    wait_done();
  endtask
`endif

  task automatic test_top_addr;
    int lat;
    int a0 = a_rv_cnt;
    int b0 = b_rv_cnt;
    issue(1'b1, 1'b0, 15'h7FFF, 16'h0000, lat);
    wait_done();
    n_cmp++;
    if (bus.b_rdata !== 16'h0000 || b_rv_cnt != b0 + 1 || a_rv_cnt != a0) begin
      n_bad++;
      $display("FAIL top_addr brd=%h b_rv=%0d a_rv=%0d, required 0000 1 0",
               bus.b_rdata, b_rv_cnt - b0, a_rv_cnt - a0);
    end
  endtask

  task automatic test_back_to_back;
    int c = 0;
    int ta = 0;
    int tb = 0;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 15'h0010; bus.a_wdata = 16'h1234;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 15'h0010;
    while ((ta == 0 || tb == 0) && c < 16) begin
      @(negedge clk);
      c++;
      if (bus.a_gnt === 1'b1) begin
        ta = c;
        shadow[16] = 16'h1234;
        bus.a_req = 1'b0;
      end
      if (bus.b_gnt === 1'b1) begin
        tb = c;
        exp_b.push_back(sh(15'h0010));
        bus.b_req = 1'b0;
      end
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    n_cmp++;
    if (ta != 1 || tb != 3) begin
      n_bad++;
      $display("FAIL b2b_timing a_gnt@%0d b_gnt@%0d, required 1 3", ta, tb);
    end
    wait_done();
    n_cmp++;
    if (bus.b_rdata !== 16'h1234) begin
      n_bad++;
      $display("FAIL b2b_data brd=%h, required 1234", bus.b_rdata);
    end
  endtask

  task automatic test_reset_mid;
    int c = 0;
    int lat;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 15'h0020; bus.a_wdata = 16'hFFFF;
    do begin
      @(negedge clk);
      c++;
    end while (bus.a_gnt !== 1'b1 && c < 16);
    bus.a_req = 1'b0;
    n_cmp++;
    if (bus.ram_load !== 1'b1 || bus.ram_address !== 15'h0020) begin
      n_bad++;
      $display("FAIL mid_access load=%b addr=%h, required 1 0020", bus.ram_load, bus.ram_address);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.ram_load, bus.busy,
         bus.ram_address, bus.ram_in, bus.a_rdata, bus.b_rdata} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset load=%b busy=%b addr=%h in=%h ard=%h brd=%h, required all 0",
               bus.ram_load, bus.busy, bus.ram_address, bus.ram_in, bus.a_rdata, bus.b_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 1'b0, 15'h0020, 16'h0000, lat);
    wait_done();
    n_cmp++;
    if (bus.a_rdata !== 16'h0000) begin
      n_bad++;
      $display("FAIL lost_write ard=%h, required 0000", bus.a_rdata);
    end
  endtask

  task automatic test_mixed;
    int lat;
    logic [DW-1:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom);
      issue(1'($urandom_range(0, 1)), 1'b1, 15'(15'h0300 + i), d, lat);
    end
    issue(1'b1, 1'b1, 15'h0000, 16'hA5A5, lat);
    for (int i = 0; i < 4; i++) begin
      issue(1'($urandom_range(0, 1)), 1'b0, 15'(15'h0300 + i), 16'h0000, lat);
    end
    issue(1'b0, 1'b0, 15'h0000, 16'h0000, lat);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    test_reset();
    test_write_read();
    test_reset();
`ifndef RAM_ARB_RR_EN
    test_fixed_prio();
`else
    test_round_robin();
`endif
    test_top_addr();
    test_reset();
    test_back_to_back();
    test_reset_mid();
    test_mixed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
